f2c_ring_arb: RTL
=================

# f2c_ring_arb

Packet-granular round-robin arbiter that shares the single FPGA-to-CPU packet ring buffer and descriptor ring buffer between NUM_REQ PDU-generating requesters. It sits between several PDU generator pipelines and the PCIe packet/descriptor buffers. It admits a packet only when both rings can absorb a worst-case packet, locks the grant until end-of-packet, and emits one descriptor per packet with a flit count it measures itself.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- MAX_PKT_FLITS, MAX_PKT_SIZE, worst-case packet length in flits
- PIPE_SLACK, 5, ring slots reserved for in-flight pipeline writes
- GW, $clog2(NUM_REQ), grant index width (derived)

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_flit  in  NUM_REQ x flit_lite_t  per-requester flit (data, sop, eop)
- req_valid  in  NUM_REQ  flit valid
- req_ready  out  NUM_REQ  flit accepted when valid && ready
- req_desc  in  NUM_REQ x pkt_desc_t  queue ids; sampled on the accepted eop flit
- pcie_pkt_buf_wr_data  out  flit_lite_t  flit to packet ring
- pcie_pkt_buf_wr_en  out  1  packet ring write strobe
- pcie_pkt_buf_occup  in  F2C_RB_AWIDTH  packet ring occupancy
- pcie_desc_buf_wr_data  out  pkt_desc_t  descriptor to descriptor ring
- pcie_desc_buf_wr_en  out  1  descriptor ring write strobe
- pcie_desc_buf_occup  in  F2C_RB_AWIDTH  descriptor ring occupancy
- grant_id  out  GW  current/last granted requester
- busy  out  1  high in XFER
- pkt_count  out  32  packets completed, wraps
- err_count  out  16  protocol errors, saturates at 16'hFFFF

## Operation
- States: IDLE and XFER.
- Space check: space_ok = pcie_pkt_buf_occup < F2C_RB_DEPTH - PIPE_SLACK - MAX_PKT_FLITS, and pcie_desc_buf_occup < F2C_RB_DEPTH - PIPE_SLACK.
- IDLE:
  - Candidates are requesters with req_valid && req_flit.sop.
  - If space_ok and any candidate exists, pick the first candidate searching from last_grant+1 with wrap-around.
  - On a pick: register grant_id, clear the flit counter, go to XFER.
  - No flit is accepted in the grant cycle.
- IDLE, non-sop flit: any requester presenting valid without sop gets req_ready=1 in IDLE. The flit is dropped and err_count increments by one per cycle (not per requester). This happens even when space_ok=0.
- XFER:
  - req_ready[grant_id]=1 only; all other ready bits are 0. Ready is combinational from state and grant_id.
  - Each accepted flit is written one cycle later with wr_en=1 and increments the 16-bit flit counter (saturating).
- Mid-packet sop: an accepted flit with sop=1 and not first in the packet is written with sop forced to 0, and err_count increments.
- Accepted eop:
  - The descriptor is written in the same cycle as that flit: dsc_queue_id/pkt_queue_id come from req_desc[grant_id]; size = counter including this flit.
  - pkt_count increments, last_grant <= grant_id, go to IDLE.
- The space check applies only at grant. A granted packet always completes, since the reservation covers it.

## Timing
- Reset values:
  - all outputs 0, including wr_en, wr_data, req_ready, grant_id, busy and both counters;
  - state IDLE;
  - last_grant = NUM_REQ-1, so the first pick is requester 0.
- Latency is 1 cycle from flit acceptance to pcie_pkt_buf_wr_en. Output data and descriptor are registered.
- Throughput:
  - a 1-flit (sop and eop) packet costs 2 cycles: grant, then transfer;
  - an N-flit packet with no valid bubbles costs N+1 cycles.
- A valid gap inside a packet holds the grant and produces no write that cycle.
- Occupancy at exactly the threshold gives no grant.
- An eop in the same cycle as a new sop candidate: the next grant is decided in the following IDLE cycle with the updated last_grant.
- Reset asserted mid-packet clears immediately. A partial packet may remain in the ring. Ring and requesters are reset together.

## Structure
- flit_lite_t, pkt_desc_t, F2C_RB_DEPTH, F2C_RB_AWIDTH and MAX_PKT_SIZE stay in the shared struct package.
- Add an arb_state_t enum (IDLE, XFER) to that package.
- One sub-module: rr_pick. It is combinational: it takes a NUM_REQ request vector and a last index, and returns a found flag and an index. It is reusable by other queue schedulers.

## Test plan
- Requester 0 sends a 3-flit packet (queue ids 5/7), rings empty -> 3 writes starting 2 cycles after the first valid. sop on the first write only, eop on the third. One descriptor {5,7,size=3} on the eop write; pkt_count=1.
- Requesters 0..3 all hold 1-flit packets continuously -> grants in order 0,1,2,3,0. Each packet costs 2 cycles. No requester is granted twice before all others are served.
- pcie_pkt_buf_occup = F2C_RB_DEPTH-PIPE_SLACK-MAX_PKT_FLITS with a pending sop -> no grant and no ready. Drop occup by 1 -> grant on the next cycle.
- Granted 4-flit packet, then occupancy rises to full mid-packet -> all 4 flits are still written and the descriptor size is 4.
- Requester 2 presents a non-sop flit in IDLE -> accepted and dropped, err_count=1, no ring write. A mid-packet sop on the granted stream -> written with sop=0 and err_count increments.
- Assert rst during flit 2 of 5 -> next cycle all outputs 0 and state IDLE. The first grant after release goes to requester 0.

Source files
------------

// File: rtl/f2c_ring_arb_pkg.sv
// Shared types and ring geometry for the FPGA-to-CPU ring arbiter and its neighbours.
package f2c_ring_arb_pkg;

  localparam int F2C_RB_DEPTH  = 256;
  localparam int F2C_RB_AWIDTH = 9;
  localparam int MAX_PKT_SIZE  = 16;
  localparam int FLIT_DW       = 32;
  localparam int QID_W         = 8;

  typedef struct packed {
    logic [FLIT_DW-1:0] data;
    logic               sop;
    logic               eop;
  } flit_lite_t;

  typedef struct packed {
    logic [QID_W-1:0] dsc_queue_id;
    logic [QID_W-1:0] pkt_queue_id;
    logic [15:0]      size;
  } pkt_desc_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/f2c_ring_arb_if.sv
// Requester-side flit/descriptor buses and ring write ports of the arbiter.
interface f2c_ring_arb_if
  import f2c_ring_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  flit_lite_t [NUM_REQ-1:0]   req_flit;
  logic       [NUM_REQ-1:0]   req_valid;
  logic       [NUM_REQ-1:0]   req_ready;
  pkt_desc_t  [NUM_REQ-1:0]   req_desc;

  flit_lite_t                 pcie_pkt_buf_wr_data;
  logic                       pcie_pkt_buf_wr_en;
  logic [F2C_RB_AWIDTH-1:0]   pcie_pkt_buf_occup;
  pkt_desc_t                  pcie_desc_buf_wr_data;
  logic                       pcie_desc_buf_wr_en;
  logic [F2C_RB_AWIDTH-1:0]   pcie_desc_buf_occup;

  modport master (
    input  req_flit, req_valid, req_desc, pcie_pkt_buf_occup, pcie_desc_buf_occup,
    output req_ready, pcie_pkt_buf_wr_data, pcie_pkt_buf_wr_en,
           pcie_desc_buf_wr_data, pcie_desc_buf_wr_en
  );

  modport slave (
    output req_flit, req_valid, req_desc, pcie_pkt_buf_occup, pcie_desc_buf_occup,
    input  req_ready, pcie_pkt_buf_wr_data, pcie_pkt_buf_wr_en,
           pcie_desc_buf_wr_data, pcie_desc_buf_wr_en
  );

endinterface

// File: rtl/f2c_ring_arb_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  int          pos;
  logic [W-1:0] pos_w;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    pos_w = '0;
    for (int k = 1; k <= N; k++) begin
      pos   = (int'(last) + k) % N;
      pos_w = W'(pos);
      if (!found && req[pos_w]) begin
        found = 1'b1;
        idx   = pos_w;
      end
    end
  end

endmodule

// File: rtl/f2c_ring_arb.sv
// Packet-granular round-robin arbiter sharing the F2C packet and descriptor rings.
// Grant is taken only when both rings can hold a worst-case packet and held to eop.
module f2c_ring_arb
  import f2c_ring_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int MAX_PKT_FLITS = MAX_PKT_SIZE,
  parameter  int PIPE_SLACK    = 5,
  localparam int GW            = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  f2c_ring_arb_if.master       bus,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [31:0]          pkt_count,
  output logic [15:0]          err_count
);

  localparam logic [F2C_RB_AWIDTH-1:0] PKT_LIMIT =
    F2C_RB_AWIDTH'(F2C_RB_DEPTH - PIPE_SLACK - MAX_PKT_FLITS);
  localparam logic [F2C_RB_AWIDTH-1:0] DESC_LIMIT =
    F2C_RB_AWIDTH'(F2C_RB_DEPTH - PIPE_SLACK);

  arb_state_t   state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [15:0]  cnt_q, cnt_d;
  flit_lite_t   wr_data_q, wr_data_d;
  logic         wr_en_q, wr_en_d;
  pkt_desc_t    desc_q, desc_d;
  logic         desc_en_q, desc_en_d;
  logic [31:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0]  err_q, err_d;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] nosop;
  logic               space_ok;
  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  flit_lite_t         g_flit;
  pkt_desc_t          g_desc;

  always_comb begin
    cand  = '0;
    nosop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i]  = bus.req_valid[i] &&  bus.req_flit[i].sop;
      nosop[i] = bus.req_valid[i] && !bus.req_flit[i].sop;
    end
  end

  assign space_ok = (bus.pcie_pkt_buf_occup < PKT_LIMIT) &&
                    (bus.pcie_desc_buf_occup < DESC_LIMIT);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (cand),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Stray non-sop flits are swallowed in IDLE so a broken requester cannot wedge the ring.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE) bus.req_ready = nosop;
    else                 bus.req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    desc_d    = desc_q;
    desc_en_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    g_flit    = bus.req_flit[grant_q];
    g_desc    = bus.req_desc[grant_q];
    unique case (state_q)
      IDLE: begin
        if (|nosop) err_d = sat_inc16(err_q);
        if (space_ok && pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.req_valid[grant_q]) begin
          wr_en_d   = 1'b1;
          wr_data_d = g_flit;
          cnt_d     = sat_inc16(cnt_q);
          if (g_flit.sop && cnt_q != 16'd0) begin
            wr_data_d.sop = 1'b0;
            err_d         = sat_inc16(err_q);
          end
          if (g_flit.eop) begin
            desc_en_d   = 1'b1;
            desc_d      = g_desc;
            desc_d.size = sat_inc16(cnt_q);
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            last_d      = grant_q;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      cnt_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      desc_q    <= '0;
      desc_en_q <= 1'b0;
      pkt_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      desc_q    <= desc_d;
      desc_en_q <= desc_en_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.pcie_pkt_buf_wr_data  = wr_data_q;
  assign bus.pcie_pkt_buf_wr_en    = wr_en_q;
  assign bus.pcie_desc_buf_wr_data = desc_q;
  assign bus.pcie_desc_buf_wr_en   = desc_en_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);
  assign pkt_count = pkt_cnt_q;
  assign err_count = err_q;

endmodule
